// File: rtl/cursor_window_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_window_ctrl
//
// Cursor / viewport controller for the Game of Life board. Converts debounced
// direction and action levels into an absolute cursor position plus a
// scrolling view window over a GRID_W x GRID_H board. It provides:
//   - a repeat FSM (IDLE / DELAY / REPEAT) for auto-repeat on held directions
//   - cursor mode (follow-scroll, clamp or wrap at the edges)
//   - pan mode (window moves, cursor keeps its offset in the window)
//   - centre, home and a cell-toggle strobe
//
// Optional build feature: define CURSOR_BLINK_EN to build the blink counter.
// Without it, cur_blink is constant 1.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   mode            0 = cursor move, 1 = window pan
//   win_ctrl_cmd    levels: [0] up [1] down [2] left [3] right
//                           [4] centre [5] home [6] toggle cell
//   view_width/_height  requested window size (clamped to 1..GRID)
//   win_x, win_y    window top-left corner
//   cur_x, cur_y    absolute cursor position
//   toggle_valid/_x/_y  one-cycle toggle strobe with its cell coordinate
//   cur_blink       cursor visibility for the renderer
//
// Strobe semantics: toggle_valid is a push-only strobe with no ready. It is
// high for exactly one cycle per rising edge of cmd[6], and toggle_x/toggle_y
// are valid in that cycle and hold their value until the next strobe.
//
// The repeat FSM state is visible on the internal signal rpt_state.
// -----------------------------------------------------------------------------
module cursor_window_ctrl #(
  parameter int COORD_W      = 5,
  parameter int GRID_W       = 32,
  parameter int GRID_H       = 32,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int WRAP         = 0,
  parameter int BLINK_DIV    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [6:0]         win_ctrl_cmd,
  input  logic [COORD_W:0]   view_width,
  input  logic [COORD_W:0]   view_height,
  output logic [COORD_W-1:0] win_x,
  output logic [COORD_W-1:0] win_y,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               toggle_valid,
  output logic [COORD_W-1:0] toggle_x,
  output logic [COORD_W-1:0] toggle_y,
  output logic               cur_blink
);

  // Arithmetic width: one extra bit holds GRID (which may be 2^COORD_W),
  // and a second extra bit gives headroom for the sums below.
  localparam int AW     = COORD_W + 2;
  localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W  = $clog2(RMAX) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  rpt_state_t       rpt_state;
  logic [CNT_W-1:0] rpt_cnt;

  // Edge detection. A bit only produces a rising edge once it has been seen
  // low after reset (armed), so a key held through reset is ignored until
  // it is released.
  logic [6:0] cmd_q;
  logic [6:0] armed;
  logic [6:0] rise;
  logic [3:0] dir;
  logic       step;

  assign rise = win_ctrl_cmd & ~cmd_q & armed;
  assign dir  = win_ctrl_cmd[3:0];

  // A step fires on any new direction edge, or when the running counter
  // expires. Nothing fires once all directions are released.
  assign step = (dir != 4'd0) &&
                ((rise[3:0] != 4'd0) || ((rpt_state != IDLE) && (rpt_cnt == '0)));

  // ---------------------------------------------------------------------------
  // Per-axis helpers
  // ---------------------------------------------------------------------------
  function automatic logic [AW-1:0] clamp_v(input logic [COORD_W:0] req,
                                            input logic [AW-1:0]    grid);
    logic [AW-1:0] r;
    r = AW'(req);
    if (r == '0)
      return AW'(1);
    else if (r > grid)
      return grid;
    else
      return r;
  endfunction

  // Restore the window invariant: clamp win to GRID-V, then follow the cursor.
  function automatic void normalize(input  logic [AW-1:0] c,
                                    input  logic [AW-1:0] w,
                                    input  logic [AW-1:0] v,
                                    input  logic [AW-1:0] g,
                                    output logic [AW-1:0] w_o);
    w_o = (w > g - v) ? g - v : w;
    if (c < w_o)
      w_o = c;
    else if (c > w_o + v - AW'(1))
      w_o = c - v + AW'(1);
  endfunction

  function automatic logic [AW-1:0] centre_win(input logic [AW-1:0] c,
                                               input logic [AW-1:0] v,
                                               input logic [AW-1:0] g);
    logic [AW-1:0] t;
    t = (c >= (v >> 1)) ? c - (v >> 1) : '0;
    return (t > g - v) ? g - v : t;
  endfunction

  // One direction step on one axis. Opposite directions cancel.
  function automatic void step_axis(input  logic [AW-1:0] c,
                                    input  logic [AW-1:0] w,
                                    input  logic [AW-1:0] v,
                                    input  logic [AW-1:0] g,
                                    input  logic          dec,
                                    input  logic          inc,
                                    input  logic          pan,
                                    output logic [AW-1:0] c_o,
                                    output logic [AW-1:0] w_o);
    c_o = c;
    w_o = w;
    if (dec != inc) begin
      if (pan) begin
        // Pan moves window and cursor together; a clamped window blocks both.
        if (inc && (w < g - v)) begin
          w_o = w + AW'(1);
          c_o = c + AW'(1);
        end else if (dec && (w != '0)) begin
          w_o = w - AW'(1);
          c_o = c - AW'(1);
        end
      end else begin
        if (inc)
          c_o = (c == g - AW'(1)) ? ((WRAP != 0) ? '0 : c) : c + AW'(1);
        else
          c_o = (c == '0) ? ((WRAP != 0) ? g - AW'(1) : c) : c - AW'(1);
        normalize(c_o, w, v, g, w_o);
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state datapath
  // ---------------------------------------------------------------------------
  logic [AW-1:0] gw, gh, vw, vh;
  logic [AW-1:0] cx, cy, wx_n, wy_n;
  logic [AW-1:0] nx_cx, nx_cy, nx_wx, nx_wy;

  assign gw = AW'(GRID_W);
  assign gh = AW'(GRID_H);
  assign cx = AW'(cur_x);
  assign cy = AW'(cur_y);

  always_comb begin
    vw    = clamp_v(view_width, gw);
    vh    = clamp_v(view_height, gh);
    wx_n  = '0;
    wy_n  = '0;
    // Window size may have changed since last cycle: fix the invariant on
    // the current position first, then apply this cycle's command to it.
    normalize(cx, AW'(win_x), vw, gw, wx_n);
    normalize(cy, AW'(win_y), vh, gh, wy_n);
    nx_cx = cx;
    nx_cy = cy;
    nx_wx = wx_n;
    nx_wy = wy_n;
    if (rise[5]) begin
      nx_cx = '0;
      nx_cy = '0;
      nx_wx = '0;
      nx_wy = '0;
    end else if (rise[4]) begin
      nx_wx = centre_win(cx, vw, gw);
      nx_wy = centre_win(cy, vh, gh);
    end else if (step) begin
      step_axis(cx, wx_n, vw, gw, dir[2], dir[3], mode, nx_cx, nx_wx);
      step_axis(cy, wy_n, vh, gh, dir[0], dir[1], mode, nx_cy, nx_wy);
    end
  end

  // ---------------------------------------------------------------------------
  // Edge-detect registers and repeat FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      armed     <= '0;
      rpt_state <= IDLE;
      rpt_cnt   <= '0;
    end else begin
      cmd_q <= win_ctrl_cmd;
      armed <= armed | ~win_ctrl_cmd;
      if (dir == 4'd0) begin
        rpt_state <= IDLE;
        rpt_cnt   <= '0;
      end else if (rise[3:0] != 4'd0) begin
        rpt_state <= DELAY;
        rpt_cnt   <= CNT_W'(REPEAT_DELAY - 1);
      end else if (rpt_state != IDLE) begin
        if (rpt_cnt == '0) begin
          rpt_state <= REPEAT;
          rpt_cnt   <= CNT_W'(REPEAT_RATE - 1);
        end else begin
          rpt_cnt <= rpt_cnt - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Position and toggle registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_x        <= '0;
      cur_y        <= '0;
      win_x        <= '0;
      win_y        <= '0;
      toggle_valid <= 1'b0;
      toggle_x     <= '0;
      toggle_y     <= '0;
    end else begin
      cur_x <= COORD_W'(nx_cx);
      cur_y <= COORD_W'(nx_cy);
      win_x <= COORD_W'(nx_wx);
      win_y <= COORD_W'(nx_wy);
      // Capture the pre-move cursor so a toggle pressed together with a
      // direction hits the cell the user was looking at.
      toggle_valid <= rise[6];
      if (rise[6]) begin
        toggle_x <= cur_x;
        toggle_y <= cur_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Cursor blink
  // ---------------------------------------------------------------------------
`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1) + 1;
  logic [BW-1:0] blink_cnt;
  logic          cur_moved;

  assign cur_moved = (nx_cx != cx) || (nx_cy != cy);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      cur_blink <= 1'b1;
    end else if (cur_moved) begin
      // Keep the cursor visible while it is moving.
      blink_cnt <= '0;
      cur_blink <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      cur_blink <= ~cur_blink;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end
`else
  // Blink disabled: cursor always visible. BLINK_DIV only matters when the
  // blink counter is built.
  assign cur_blink = (BLINK_DIV > 0) | 1'b1;
`endif

endmodule

// File: tb/tb_cursor_window_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cursor_window_ctrl. Two instances share all inputs: dut uses
// WRAP=0 (saturating edges), dut_w uses WRAP=1 (wrapping edges). Each test
// task drives directed stimulus and compares outputs against hand-computed
// values (VW=VH=8 on a 32x32 board unless noted).
// -----------------------------------------------------------------------------
module tb_cursor_window_ctrl;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [6:0]    cmd;
  logic [CW:0]   vw;
  logic [CW:0]   vh;

  logic [CW-1:0] a_win_x, a_win_y, a_cur_x, a_cur_y, a_tog_x, a_tog_y;
  logic          a_tog_v, a_blink;
  logic [CW-1:0] b_win_x, b_win_y, b_cur_x, b_cur_y, b_tog_x, b_tog_y;
  logic          b_tog_v, b_blink;

  int total = 0;
  int bad   = 0;

  cursor_window_ctrl #(.COORD_W(CW), .GRID_W(32), .GRID_H(32), .REPEAT_DELAY(8),
                       .REPEAT_RATE(4), .WRAP(0), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .win_ctrl_cmd(cmd),
    .view_width(vw), .view_height(vh),
    .win_x(a_win_x), .win_y(a_win_y), .cur_x(a_cur_x), .cur_y(a_cur_y),
    .toggle_valid(a_tog_v), .toggle_x(a_tog_x), .toggle_y(a_tog_y),
    .cur_blink(a_blink)
  );

  cursor_window_ctrl #(.COORD_W(CW), .GRID_W(32), .GRID_H(32), .REPEAT_DELAY(8),
                       .REPEAT_RATE(4), .WRAP(1), .BLINK_DIV(16)) dut_w (
    .clk(clk), .rst(rst), .mode(mode), .win_ctrl_cmd(cmd),
    .view_width(vw), .view_height(vh),
    .win_x(b_win_x), .win_y(b_win_y), .cur_x(b_cur_x), .cur_y(b_cur_y),
    .toggle_valid(b_tog_v), .toggle_x(b_tog_x), .toggle_y(b_tog_y),
    .cur_blink(b_blink)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      cmd[b] = 1'b1;
      tick;
      cmd[b] = 1'b0;
      tick;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst  = 1'b1;
    mode = 1'b0;
    cmd  = '0;
    vw   = 6'd8;
    vh   = 6'd8;
    repeat (3) tick;
    rst = 1'b0;
    repeat (2) tick;
    total++; if (a_win_x !== 5'd0) begin bad++; $display("FAIL reset_win_x got %0d want 0", a_win_x); end
    total++; if (a_win_y !== 5'd0) begin bad++; $display("FAIL reset_win_y got %0d want 0", a_win_y); end
    total++; if (a_cur_x !== 5'd0) begin bad++; $display("FAIL reset_cur_x got %0d want 0", a_cur_x); end
    total++; if (a_cur_y !== 5'd0) begin bad++; $display("FAIL reset_cur_y got %0d want 0", a_cur_y); end
    total++; if (a_tog_v !== 1'b0) begin bad++; $display("FAIL reset_toggle_valid got %0b want 0", a_tog_v); end
    total++; if (a_tog_x !== 5'd0) begin bad++; $display("FAIL reset_toggle_x got %0d want 0", a_tog_x); end
    total++; if (a_blink !== 1'b1) begin bad++; $display("FAIL reset_blink got %0b want 1", a_blink); end
    total++; if (b_cur_x !== 5'd0) begin bad++; $display("FAIL reset_wrap_cur_x got %0d want 0", b_cur_x); end
  endtask

  // Held right: steps on edges 0, 8, 12, 16 of a 20-edge hold.
  task automatic test_repeat;
    logic [CW-1:0] e;
    cmd[3] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick;
      e = CW'(1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16));
      total++;
      if (a_cur_x !== e) begin
        bad++; $display("FAIL repeat_cur_x edge %0d got %0d want %0d", k, a_cur_x, e);
      end
    end
    cmd[3] = 1'b0;
    tick;
    total++; if (a_cur_x !== 5'd4) begin bad++; $display("FAIL repeat_final_cur_x got %0d want 4", a_cur_x); end
    total++; if (a_win_x !== 5'd0) begin bad++; $display("FAIL repeat_final_win_x got %0d want 0", a_win_x); end
    // Left+right cancel on x, down still moves y.
    cmd[1] = 1'b1; cmd[2] = 1'b1; cmd[3] = 1'b1;
    repeat (3) tick;
    total++; if (a_cur_x !== 5'd4) begin bad++; $display("FAIL opposite_cur_x got %0d want 4", a_cur_x); end
    total++; if (a_cur_y !== 5'd1) begin bad++; $display("FAIL opposite_cur_y got %0d want 1", a_cur_y); end
    cmd = '0;
    tick;
  endtask

  task automatic test_follow;
    pulse(5, 1);
    pulse(3, 7);
    total++; if (a_cur_x !== 5'd7) begin bad++; $display("FAIL follow_pre_cur_x got %0d want 7", a_cur_x); end
    total++; if (a_win_x !== 5'd0) begin bad++; $display("FAIL follow_pre_win_x got %0d want 0", a_win_x); end
    pulse(3, 1);
    total++; if (a_cur_x !== 5'd8) begin bad++; $display("FAIL follow_cur_x got %0d want 8", a_cur_x); end
    total++; if (a_win_x !== 5'd1) begin bad++; $display("FAIL follow_win_x got %0d want 1", a_win_x); end
    vw = 6'd4;
    tick;
    total++; if (a_win_x !== 5'd5) begin bad++; $display("FAIL shrink_win_x got %0d want 5", a_win_x); end
    vw = 6'd0;    // clamps to width 1: window sits on the cursor
    tick;
    total++; if (a_win_x !== 5'd8) begin bad++; $display("FAIL width0_win_x got %0d want 8", a_win_x); end
    vw = 6'd63;   // clamps to the full board: window pinned at 0
    tick;
    total++; if (a_win_x !== 5'd0) begin bad++; $display("FAIL width_big_win_x got %0d want 0", a_win_x); end
    vw = 6'd8;
    tick;
    total++; if (a_win_x !== 5'd1) begin bad++; $display("FAIL width8_win_x got %0d want 1", a_win_x); end
    total++; if (a_cur_x !== 5'd8) begin bad++; $display("FAIL resize_cur_x got %0d want 8", a_cur_x); end
  endtask

  task automatic test_edge;
    pulse(5, 1);
    pulse(3, 31);
    total++; if (a_cur_x !== 5'd31) begin bad++; $display("FAIL edge_pre_cur_x got %0d want 31", a_cur_x); end
    total++; if (b_cur_x !== 5'd31) begin bad++; $display("FAIL edge_pre_wrap_cur_x got %0d want 31", b_cur_x); end
    pulse(3, 1);
    total++; if (a_cur_x !== 5'd31) begin bad++; $display("FAIL sat_cur_x got %0d want 31", a_cur_x); end
    total++; if (a_win_x !== 5'd24) begin bad++; $display("FAIL sat_win_x got %0d want 24", a_win_x); end
    total++; if (b_cur_x !== 5'd0) begin bad++; $display("FAIL wrap_cur_x got %0d want 0", b_cur_x); end
    total++; if (b_win_x !== 5'd0) begin bad++; $display("FAIL wrap_win_x got %0d want 0", b_win_x); end
    pulse(5, 1);
    pulse(2, 1);
    total++; if (a_cur_x !== 5'd0) begin bad++; $display("FAIL sat_low_cur_x got %0d want 0", a_cur_x); end
    total++; if (b_cur_x !== 5'd31) begin bad++; $display("FAIL wrap_low_cur_x got %0d want 31", b_cur_x); end
    total++; if (b_win_x !== 5'd24) begin bad++; $display("FAIL wrap_low_win_x got %0d want 24", b_win_x); end
    pulse(5, 1);
  endtask

  task automatic test_pan;
    pulse(3, 3);
    mode = 1'b1;
    pulse(3, 1);
    total++; if (a_win_x !== 5'd1) begin bad++; $display("FAIL pan_win_x got %0d want 1", a_win_x); end
    total++; if (a_cur_x !== 5'd4) begin bad++; $display("FAIL pan_cur_x got %0d want 4", a_cur_x); end
    pulse(3, 23);
    total++; if (a_win_x !== 5'd24) begin bad++; $display("FAIL pan_max_win_x got %0d want 24", a_win_x); end
    total++; if (a_cur_x !== 5'd27) begin bad++; $display("FAIL pan_max_cur_x got %0d want 27", a_cur_x); end
    pulse(3, 1);
    total++; if (a_win_x !== 5'd24) begin bad++; $display("FAIL pan_clamp_win_x got %0d want 24", a_win_x); end
    total++; if (a_cur_x !== 5'd27) begin bad++; $display("FAIL pan_clamp_cur_x got %0d want 27", a_cur_x); end
    total++; if (b_cur_x !== 5'd27) begin bad++; $display("FAIL pan_wrap_cur_x got %0d want 27", b_cur_x); end
    pulse(5, 1);
    pulse(0, 1);
    total++; if (a_win_y !== 5'd0) begin bad++; $display("FAIL pan_low_win_y got %0d want 0", a_win_y); end
    total++; if (a_cur_y !== 5'd0) begin bad++; $display("FAIL pan_low_cur_y got %0d want 0", a_cur_y); end
    mode = 1'b0;
    tick;
  endtask

  task automatic test_toggle;
    int pulses;
    pulse(5, 1);
    pulse(3, 5);
    pulse(1, 9);
    total++; if (a_cur_y !== 5'd9) begin bad++; $display("FAIL tog_pre_cur_y got %0d want 9", a_cur_y); end
    total++; if (a_win_y !== 5'd2) begin bad++; $display("FAIL tog_pre_win_y got %0d want 2", a_win_y); end
    pulses = 0;
    cmd[6] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (a_tog_v === 1'b1) pulses++;
    end
    cmd[6] = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL toggle_pulses got %0d want 1", pulses); end
    total++; if (a_tog_x !== 5'd5) begin bad++; $display("FAIL toggle_x got %0d want 5", a_tog_x); end
    total++; if (a_tog_y !== 5'd9) begin bad++; $display("FAIL toggle_y got %0d want 9", a_tog_y); end
    tick;
    total++; if (a_tog_v !== 1'b0) begin bad++; $display("FAIL toggle_idle got %0b want 0", a_tog_v); end
    // Toggle with a simultaneous move reports the pre-move cell.
    cmd[6] = 1'b1; cmd[3] = 1'b1;
    tick;
    total++; if (a_tog_v !== 1'b1) begin bad++; $display("FAIL toggle_move_valid got %0b want 1", a_tog_v); end
    total++; if (a_tog_x !== 5'd5) begin bad++; $display("FAIL toggle_move_x got %0d want 5", a_tog_x); end
    total++; if (a_cur_x !== 5'd6) begin bad++; $display("FAIL toggle_move_cur_x got %0d want 6", a_cur_x); end
    cmd = '0;
    tick;
    pulse(4, 1);
    total++; if (a_win_x !== 5'd2) begin bad++; $display("FAIL centre_win_x got %0d want 2", a_win_x); end
    total++; if (a_win_y !== 5'd5) begin bad++; $display("FAIL centre_win_y got %0d want 5", a_win_y); end
    total++; if (a_cur_x !== 5'd6) begin bad++; $display("FAIL centre_cur_x got %0d want 6", a_cur_x); end
    // Home wins over a direction edge in the same cycle.
    cmd[5] = 1'b1; cmd[3] = 1'b1;
    tick;
    total++; if (a_cur_x !== 5'd0) begin bad++; $display("FAIL home_cur_x got %0d want 0", a_cur_x); end
    total++; if (a_cur_y !== 5'd0) begin bad++; $display("FAIL home_cur_y got %0d want 0", a_cur_y); end
    total++; if (a_win_x !== 5'd0) begin bad++; $display("FAIL home_win_x got %0d want 0", a_win_x); end
    total++; if (a_win_y !== 5'd0) begin bad++; $display("FAIL home_win_y got %0d want 0", a_win_y); end
    cmd = '0;
    tick;
  endtask

  task automatic test_reset_hold;
    cmd[3] = 1'b1;
    repeat (2) tick;
    total++; if (a_cur_x !== 5'd1) begin bad++; $display("FAIL hold_pre_cur_x got %0d want 1", a_cur_x); end
    rst = 1'b1;
    tick;
    total++; if (a_cur_x !== 5'd0) begin bad++; $display("FAIL hold_in_reset_cur_x got %0d want 0", a_cur_x); end
    rst = 1'b0;
    repeat (12) tick;
    total++; if (a_cur_x !== 5'd0) begin bad++; $display("FAIL hold_after_reset_cur_x got %0d want 0", a_cur_x); end
    cmd[3] = 1'b0;
    tick;
    pulse(3, 1);
    total++; if (a_cur_x !== 5'd1) begin bad++; $display("FAIL rearm_cur_x got %0d want 1", a_cur_x); end
  endtask

  initial begin
    test_reset;
    test_repeat;
    test_follow;
    test_edge;
    test_pan;
    test_toggle;
    test_reset_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cursor_window_ctrl.md
Name: cursor_window_ctrl

Overview:
Parametrised cursor/viewport controller for the Game of Life board. Turns debounced direction and action commands into an absolute cursor position and a scrolling view window over a GRID_W x GRID_H cell array. Adds auto-repeat on held keys, follow-scroll, clamp or wrap at the board edges, and a cell-toggle strobe. Sits between the key debouncer and the cell-memory/VGA render path.

Parameters:
COORD_W, 5, width of every coordinate output (board up to 2^COORD_W per axis)
GRID_W, 32, board width in cells (<= 2^COORD_W)
GRID_H, 32, board height in cells (<= 2^COORD_W)
REPEAT_DELAY, 8, cycles from the first step of a held direction to the first repeat (>= 2)
REPEAT_RATE, 4, cycles between later repeats (>= 1)
WRAP, 0, 1 = cursor wraps at board edges; 0 = cursor saturates
BLINK_DIV, 16, half-period of the cursor blink, in cycles

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
mode  in  1  0 = cursor move, 1 = window pan
win_ctrl_cmd  in  7  level inputs: [0] up, [1] down, [2] left, [3] right, [4] centre, [5] home, [6] toggle cell
view_width  in  COORD_W+1  window width in cells
view_height  in  COORD_W+1  window height in cells
win_x  out  COORD_W  window left column
win_y  out  COORD_W  window top row
cur_x  out  COORD_W  cursor column (absolute)
cur_y  out  COORD_W  cursor row (absolute)
toggle_valid  out  1  one-cycle toggle strobe
toggle_x  out  COORD_W  column to toggle, valid with toggle_valid
toggle_y  out  COORD_W  row to toggle, valid with toggle_valid
cur_blink  out  1  cursor visibility for the renderer

Behaviour:
- Reset: every output is 0; the repeat FSM goes to IDLE; all edge-detect registers are cleared.
- Effective window size: VW = clamp(view_width, 1, GRID_W); VH = clamp(view_height, 1, GRID_H). Both are recomputed every cycle.
- A "step" is generated by the repeat FSM. It applies to all direction bits held in the cycle it fires. Outputs update on the next clock edge (1-cycle latency).
- Opposite directions held together (up+down or left+right): that axis does not move. The other axis still moves.
- Repeat FSM:
  - IDLE: a rising edge on any of bits [3:0] fires a step, loads the counter with REPEAT_DELAY-1 and moves to DELAY.
  - DELAY: counter reaches 0 -> step fires, counter loads REPEAT_RATE-1, move to REPEAT.
  - REPEAT: counter reaches 0 -> step fires and the counter reloads.
  - In DELAY or REPEAT, a new rising edge on any direction bit fires a step immediately and restarts DELAY.
  - All of bits [3:0] low -> IDLE, from any state.
- Cursor mode (mode=0), per axis:
  - cur +/- 1.
  - Past the board edge: WRAP=0 saturates at 0 / GRID-1. WRAP=1 wraps 0 <-> GRID-1.
  - Follow-scroll: if cur < win, set win = cur. If cur > win+V-1, set win = cur-V+1.
- Pan mode (mode=1), per axis:
  - win +/- 1, clamped to [0, GRID-V].
  - cur moves by the same delta as win, so the cursor offset inside the window is kept.
  - If win is clamped, neither win nor cur changes on that axis.
  - WRAP has no effect in pan mode.
- Window invariant, checked every cycle including after view_width/view_height change:
  - win <= GRID-V.
  - win <= cur <= win+V-1.
  - Violations are corrected on the next edge: re-clamp win first, then follow-scroll.
- Centre (rising edge of [4]): win = clamp(cur - V/2, 0, GRID-V); cur is unchanged.
- Home (rising edge of [5]): cur = 0 and win = 0.
- Priority in one cycle: home > centre > direction step.
- Toggle (rising edge of [6]): toggle_valid = 1 for exactly one cycle, with toggle_x/toggle_y = cur as held before any move in that same cycle. Holding [6] gives no further pulses. toggle_x/toggle_y hold their value between pulses.
- Reset asserted mid-hold: everything returns to the reset state. A direction still held after reset is released does not count as a new edge until it has been seen low once.

Optional Feature:
CURSOR_BLINK_EN
- Defined: cur_blink toggles every BLINK_DIV cycles. Any cursor move resets the blink counter and forces cur_blink = 1.
- Undefined: no blink counter is built; cur_blink is constant 1.
- Reset value is 1 in both builds; it overrides the all-outputs-0 reset rule for this port.

Test Plan:
1. Reset, then release with VW=VH=8 -> win_x=win_y=cur_x=cur_y=0, toggle_valid=0, cur_blink=1.
2. Hold [3] for 20 cycles from cycle t -> steps at t, t+8, t+12, t+16; final cur_x=4, win_x=0. Hold [2]+[3] together -> cur_x unchanged.
3. cur_x=7, win_x=0, VW=8, pulse [3] -> cur_x=8, win_x=1. Reduce view_width to 4 -> next cycle win_x=5.
4. WRAP=0, cur_x=31, pulse [3] -> cur_x=31, win_x=24. WRAP=1, same stimulus -> cur_x=0, win_x=0.
5. mode=1, win_x=0, cur_x=3, pulse [3] -> win_x=1, cur_x=4. From win_x=24, pulse [3] -> no change on the x axis.
6. cur=(5,9), hold [6] for 10 cycles -> a single toggle_valid pulse with toggle_x=5, toggle_y=9. Assert [5] and [3] together -> cur=(0,0), win=(0,0).
